sloth_seq_engine: RTL
=====================

// Module: sloth_seq_engine
// PURPOSE
//  Programmable sequencer for the 4-register (r0..r3) sloth datapath. Runs a loaded instruction program one op
//  per cycle instead of a fixed evolved netlist, so the GE harness scores new individuals without resynthesis.
//  Sits between the harness (program load, start/done) and the a*/b* operand sources.
// PARAMETERS
//  DATA_W     16  width of operands, registers r0..r3 and results
//  PROG_DEPTH 32  instruction memory depth (power of 2)
//  ADDR_W     $clog2(PROG_DEPTH)  derived; do not override
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         asynchronous, active-high reset
//  prog_we    in   1         write prog_data into imem[prog_addr]; honoured only when busy=0
//  prog_addr  in   ADDR_W    imem write address
//  prog_data  in   7         instruction word {op[6:5], dst[4:3], src[2:0]}
//  prog_len   in   ADDR_W+1  number of instructions to run; sampled at start
//  start      in   1         run request; accepted only when busy=0
//  a1,a0,b1,b0 in  DATA_W    operands; sampled at start
//  busy       out  1         high from accepting edge until the done edge
//  done       out  1         one-cycle pulse, results valid on y*
//  y3,y2,y1,y0 out DATA_W    r3..r0 snapshot of the last completed run
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, y3..y0=0, r0..r3=0, pc=0. imem is NOT reset (contents undefined until loaded).
//  Ops: 0 XOR  rd ^= s; 1 AND  rd &= s; 2 OR  rd |= s; 3 NOT  rd = (s==0) ? 1 : 0 (logical not, zero-extended).
//  src: 0..3 = r0..r3 (current value), 4=a0, 5=a1, 6=b0, 7=b1 (latched copies).
//  FSM IDLE -> RUN -> FIN -> IDLE.
//   IDLE: start at edge T -> r0=a0,r1=a1,r2=b0,r3=b1; latch operands; len=min(prog_len,PROG_DEPTH); pc=0; busy=1;
//         next state RUN, or FIN if len==0.
//   RUN: edge executes imem[pc] and increments pc; after the edge executing pc==len-1 -> FIN.
//        Edges T+1..T+len execute; each op sees the results of all earlier ops.
//   FIN: one edge (T+len+1): y0..y3 <= r0..r3; done=1 for that cycle; busy=0; -> IDLE.
//  Latency: start edge to done-high = len+1 cycles; y* hold their value until the next FIN.
//  start while busy: ignored (not queued). prog_we while busy: ignored, imem unchanged.
//  prog_we and start on the same IDLE edge: write completes; run uses the new word.
//  rst mid-run: immediate abort to reset values; no done pulse; imem retained.
//  Arithmetic is purely bitwise on DATA_W bits; no carries, no overflow.
// STRUCTURE
//  sloth_pkg: op_e {OP_XOR,OP_AND,OP_OR,OP_NOT}, src_e (R0..R3,A0,A1,B0,B1), instr_t packed struct,
//   state_e {IDLE,RUN,FIN}.
//  One sub-module sloth_alu: combinational (op, rd value, src value) -> result; engine holds FSM, imem, regfile.
// TESTING
//  1 Load {XOR,r1,r0},{NOT,r0,b1}; len=2; a0=00F0 a1=0F0F b0=1234 b1=0000; start ->
//    done 3 cycles later; y0=0001 y1=0FFF y2=1234 y3=0000.
//  2 len=0; a0=1111 a1=2222 b0=3333 b1=4444 -> done after 1 cycle; y0=1111 y1=2222 y2=3333 y3=4444.
//  3 Fill all 32 slots with {OR,r2,a0}; len=40 (clamped to 32); a0=8001, b0=0 -> done after 33 cycles; y2=8001.
//  4 During test-1 run: pulse start and prog_we imem[0]={AND,r1,b1} -> both ignored; result matches test 1;
//    rerun also matches test 1.
//  5 Assert rst mid-run -> busy=0, done never pulses, y*=0; rerun without reloading gives test-1 result.
//  6 {NOT,r3,r3} with b1=0000, then {NOT,r3,r3} again -> y3=0000
//    (chain 0->1->0 checks logical not and in-order use of r3).

Source files
------------

// File: rtl/sloth_pkg.sv
// Shared types for the sloth sequencer: opcodes, operand selects,
// the 7-bit instruction word and the engine state encoding.
package sloth_pkg;

    typedef enum logic [1:0] {
        OP_XOR = 2'd0,
        OP_AND = 2'd1,
        OP_OR  = 2'd2,
        OP_NOT = 2'd3
    } op_e;

    // r0..r3 read the live register file; A*/B* read the copies latched at start
    typedef enum logic [2:0] {
        R0 = 3'd0,
        R1 = 3'd1,
        R2 = 3'd2,
        R3 = 3'd3,
        A0 = 3'd4,
        A1 = 3'd5,
        B0 = 3'd6,
        B1 = 3'd7
    } src_e;

    typedef struct packed {
        op_e        op;
        logic [1:0] dst;
        src_e       src;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int INSTR_W = $bits(instr_t);

    // True when the source field selects one of r0..r3
    function automatic logic src_is_reg(input src_e s);
        logic [2:0] v;
        v = s;
        return ~v[2];
    endfunction

endpackage

// File: rtl/sloth_alu.sv
// Single-op bitwise ALU for the sloth engine. NOT is a logical not of the
// source, zero-extended, so chains of NOT toggle between 0 and 1.
module sloth_alu
    import sloth_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] rd_val,
    input  logic [DATA_W-1:0] src_val,
    output logic [DATA_W-1:0] result
);

    // Result of applying op to the destination and source values
    always_comb begin
        result = '0;
        unique case (op)
            OP_XOR: result = rd_val ^ src_val;
            OP_AND: result = rd_val & src_val;
            OP_OR:  result = rd_val | src_val;
            OP_NOT: result = {{(DATA_W-1){1'b0}}, (src_val == '0)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/sloth_seq_engine.sv
// Programmable sequencer for the four-register sloth datapath. Executes
// one instruction from imem per cycle, then snapshots r0..r3 onto y0..y3.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for start; imem writable; y* hold last snapshot
//  RUN   | executing imem[pc] each edge; rem counts instructions left
//  FIN   | copy r0..r3 to y0..y3, pulse done, return to IDLE
module sloth_seq_engine
    import sloth_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int PROG_DEPTH = 32,
    localparam int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [6:0]        prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b0,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] y3,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y0
);

    localparam int LEN_W = ADDR_W + 1;

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [LEN_W-1:0]  rem;
    logic [LEN_W-1:0]  len_clamped;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] a0_q, a1_q, b0_q, b1_q;
    instr_t            imem [PROG_DEPTH];
    instr_t            cur;
    logic [DATA_W-1:0] src_val, rd_val, alu_res;
    logic              accept, exec, finish;

    assign busy        = (state != IDLE);
    assign len_clamped = (prog_len > LEN_W'(PROG_DEPTH)) ? LEN_W'(PROG_DEPTH) : prog_len;
    assign cur         = imem[pc];
    assign rd_val      = regs[cur.dst];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        exec      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (len_clamped == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                exec = 1'b1;
                if (rem == LEN_W'(1)) state_nxt = FIN;
            end
            FIN: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Program memory: not reset so a loaded program survives rst; frozen while busy
    always_ff @(posedge clk) begin
        if (prog_we && (state == IDLE)) imem[prog_addr] <= instr_t'(prog_data);
    end

    // Source operand select: live registers or the operands latched at start
    always_comb begin
        src_val = '0;
        if (src_is_reg(cur.src)) begin
            src_val = regs[cur.dst == cur.dst ? cur.src[1:0] : 2'd0];
        end else begin
            unique case (cur.src)
                A0:      src_val = a0_q;
                A1:      src_val = a1_q;
                B0:      src_val = b0_q;
                B1:      src_val = b1_q;
                default: src_val = '0;
            endcase
        end
    end

    sloth_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op      (cur.op),
        .rd_val  (rd_val),
        .src_val (src_val),
        .result  (alu_res)
    );

    // Register file, operand latches, program counter and remaining-count down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            a0_q <= '0;
            a1_q <= '0;
            b0_q <= '0;
            b1_q <= '0;
            pc   <= '0;
            rem  <= '0;
        end else if (accept) begin
            regs[0] <= a0;
            regs[1] <= a1;
            regs[2] <= b0;
            regs[3] <= b1;
            a0_q    <= a0;
            a1_q    <= a1;
            b0_q    <= b0;
            b1_q    <= b1;
            pc      <= '0;
            rem     <= len_clamped;
        end else if (exec) begin
            regs[cur.dst] <= alu_res;
            pc            <= pc + ADDR_W'(1);
            rem           <= rem - LEN_W'(1);
        end
    end

    // Result snapshot and done pulse, both taken on the FIN edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            y0   <= '0;
            y1   <= '0;
            y2   <= '0;
            y3   <= '0;
        end else begin
            done <= finish;
            if (finish) begin
                y0 <= regs[0];
                y1 <= regs[1];
                y2 <= regs[2];
                y3 <= regs[3];
            end
        end
    end

endmodule
